// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the cache miss sequencing controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FILL,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam int DEFAULT_MEM_LATENCY = 20;
  localparam int DEFAULT_CNT_W       = 8;

endpackage

// File: rtl/mem_latency_counter.sv
// Cycle counter for one main-memory access; flags the last cycle of the access.
module mem_latency_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == terminal);

endmodule

// File: rtl/cache_miss_controller.sv
// Miss sequencer between the memory stage and memory_system: writeback, fetch, fill, done.
// Optional perf counters (hit/miss/writeback) are enabled with CACHE_MISS_CTRL_PERF_EN.
module cache_miss_controller
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              hit,
  input  logic              miss,
  input  logic              dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_wr_we,
  output logic              fill_rd_we,
  output logic              done
`ifdef CACHE_MISS_CTRL_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);

  state_t            state;
  state_t            state_next;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] victim_q;
  logic              req;
  logic              accept;
  logic              expired;
  logic              cnt_enable;
  logic              cnt_clear;

  assign req        = req_re | req_we;
  assign cnt_enable = (state == WB) || (state == FETCH);
  assign cnt_clear  = (state_next != state);

  mem_latency_counter #(
    .CNT_W(CNT_W)
  ) u_latency (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (CNT_W'(MEM_LATENCY - 1)),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requester inputs are only trusted in the accepting cycle; everything later uses these copies.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      victim_q <= '0;
      op_q     <= OP_RD;
    end else if (accept) begin
      addr_q   <= req_addr;
      victim_q <= victim_addr;
      op_q     <= req_we ? OP_WR : OP_RD;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    fill_wr_we = 1'b0;
    fill_rd_we = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        // A simultaneous hit and miss is a miss; a clean hit is served by the cache alone.
        if (req && miss) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = dirty ? WB : FETCH;
        end else if (req && hit) begin
          state_next = IDLE;
        end
      end
      WB: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = victim_q;
        if (expired) state_next = FETCH;
      end
      FETCH: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (expired) state_next = FILL;
      end
      FILL: begin
        stall      = 1'b1;
        fill_wr_we = (op_q == OP_WR);
        fill_rd_we = (op_q == OP_RD);
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CACHE_MISS_CTRL_PERF_EN
  // Saturating event counters; a hit seen in DONE is ignored because the cache is still settling.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if ((state == IDLE) && req && hit && !miss && (hit_count != '1))
        hit_count <= hit_count + 32'd1;
      if (accept && (miss_count != '1))
        miss_count <= miss_count + 32'd1;
      if (accept && dirty && (wb_count != '1))
        wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Scoreboard bench: each accepted miss queues its expected timeline, checked every cycle.
module tb_cache_miss_controller;

  localparam int LAT = 20;

  typedef struct {
    logic        wr;
    logic        dirty;
    logic [31:0] addr;
    logic [31:0] victim;
    int          start;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_re, req_we, hit, miss, dirty;
  logic [31:0] req_addr, victim_addr;
  logic        stall, mem_req, mem_wr, fill_wr_we, fill_rd_we, done;
  logic [31:0] mem_addr;
`ifdef CACHE_MISS_CTRL_PERF_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  txn_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_hit = 0, n_miss = 0, n_wb = 0;
  logic skip_mon = 1'b1;

  cache_miss_controller #(
    .ADDR_W      (32),
    .MEM_LATENCY (LAT),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_re      (req_re),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .hit         (hit),
    .miss        (miss),
    .dirty       (dirty),
    .victim_addr (victim_addr),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .fill_wr_we  (fill_wr_we),
    .fill_rd_we  (fill_rd_we),
    .done        (done)
`ifdef CACHE_MISS_CTRL_PERF_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .wb_count    (wb_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  // Drives one request for one cycle; a miss queues its expected timeline starting this cycle.
  task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr,
                               input logic h, input logic m, input logic d, input logic [31:0] victim);
    txn_t t;
    req_re = re; req_we = we; req_addr = addr;
    hit = h; miss = m; dirty = d; victim_addr = victim;
    if ((re || we) && m) begin
      t.wr = we; t.dirty = d; t.addr = addr; t.victim = victim; t.start = cyc;
      exp_q.push_back(t);
      n_miss++;
      if (d) n_wb++;
    end else if ((re || we) && h) begin
      n_hit++;
    end
    @(posedge clk); #1;
    req_re = 1'b0; req_we = 1'b0; req_addr = '0;
    hit = 1'b0; miss = 1'b0; dirty = 1'b0; victim_addr = '0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Per-cycle monitor: expected outputs come from the queued transaction's relative cycle.
  txn_t        cur;
  int          rc, wb;
  logic [5:0]  obs, ex;
  logic [31:0] ea;
  logic        pop;
  always @(negedge clk) begin
    if (!skip_mon) begin
      obs = {stall, mem_req, mem_wr, fill_wr_we, fill_rd_we, done};
      ex  = '0;
      ea  = '0;
      pop = 1'b0;
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        rc  = cyc - cur.start;
        wb  = cur.dirty ? LAT : 0;
        ex[5] = (rc <= wb + LAT + 1);
        ex[4] = (rc >= 1) && (rc <= wb + LAT);
        ex[3] = (rc >= 1) && (rc <= wb);
        ex[2] = (rc == wb + LAT + 1) && cur.wr;
        ex[1] = (rc == wb + LAT + 1) && !cur.wr;
        ex[0] = (rc == wb + LAT + 2);
        if (ex[3]) ea = cur.victim;
        else if (ex[4]) ea = cur.addr;
        pop = (rc >= wb + LAT + 2);
      end
      checkOutput("ctrl", 64'(obs), 64'(ex));
      checkOutput("mem_addr", 64'(mem_addr), 64'(ea));
      if (pop) void'(exp_q.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    req_re = 1'b0; req_we = 1'b0; req_addr = '0;
    hit = 1'b0; miss = 1'b0; dirty = 1'b0; victim_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    skip_mon = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] write hit");
    applyStimulus(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h54, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk); #1;

    $display("[TB] clean read miss");
    applyStimulus(1'b1, 1'b0, 32'h2006, 1'b0, 1'b1, 1'b0, 32'h0);
    waitDrain();

    $display("[TB] dirty write miss");
    applyStimulus(1'b0, 1'b1, 32'h1006, 1'b0, 1'b1, 1'b1, 32'h0006);
    waitDrain();

    $display("[TB] read+write on miss treated as write");
    applyStimulus(1'b1, 1'b1, 32'h3010, 1'b0, 1'b1, 1'b0, 32'h0);
    waitDrain();

    $display("[TB] hit and miss together treated as dirty read miss");
    applyStimulus(1'b1, 1'b0, 32'h4020, 1'b1, 1'b1, 1'b1, 32'h7020);
    waitDrain();

    applyStimulus(1'b1, 1'b0, 32'h60, 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] reset during fetch");
    applyStimulus(1'b1, 1'b0, 32'h5004, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    skip_mon = 1'b1;
    reset_n  = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    reset_n  = 1'b1;
    skip_mon = 1'b0;
    repeat (30) @(posedge clk); #1;

`ifdef CACHE_MISS_CTRL_PERF_EN
    $display("[TB] perf counters after reset");
    checkOutput("hit_count_rst", 64'(hit_count), 64'd0);
    checkOutput("miss_count_rst", 64'(miss_count), 64'd0);
    n_hit = 0; n_miss = 0; n_wb = 0;
    applyStimulus(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h108, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 1'b1, 32'h900);
    waitDrain();
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
    waitDrain();
    checkOutput("hit_count", 64'(hit_count), 64'(n_hit));
    checkOutput("miss_count", 64'(miss_count), 64'(n_miss));
    checkOutput("wb_count", 64'(wb_count), 64'(n_wb));
`endif

    repeat (3) @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- Sequencing FSM for `memory_system` (cache + main memory).
- Replaces today's manual bench pulsing of `we2`/`we3` after ~200 ns of main-memory latency.
- Detects read/write misses and stalls the requester.
- Writes back a dirty victim, fetches the missing block over a fixed-latency memory interface, then pulses the correct cache fill strobe.
- Sits between the pipeline memory stage and `memory_system`.

Parameters:
- ADDR_W, 32, address width.
- MEM_LATENCY, 20, cycles per main-memory access (20 × 10 ns = 200 ns); legal range 1..255.
- CNT_W, 8, latency counter width; must satisfy 2**CNT_W > MEM_LATENCY.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req_re  in  1  requester read enable
- req_we  in  1  requester write enable
- req_addr  in  ADDR_W  requester address
- hit  in  1  cache hit for req_addr (combinational from cache)
- miss  in  1  cache miss for req_addr
- dirty  in  1  indexed victim line dirty
- victim_addr  in  ADDR_W  block address of indexed victim line
- stall  out  1  hold requester
- mem_req  out  1  main-memory access in progress
- mem_wr  out  1  1 = writeback, 0 = fetch (valid with mem_req)
- mem_addr  out  ADDR_W  main-memory address
- fill_wr_we  out  1  write-miss fill strobe (cache we2)
- fill_rd_we  out  1  read-miss fill strobe (cache we3)
- done  out  1  miss serviced, one-cycle pulse

Behaviour:
- Reset: synchronous on rising clk with reset_n=0.
  - State -> IDLE; counter = 0; latched addr/op = 0.
  - All outputs 0, including stall.
  - Reset mid-operation aborts immediately; no fill pulse, no done.
- States: IDLE, WB, FETCH, FILL, DONE.
- IDLE:
  - req = req_re | req_we.
  - req & hit: no action, stall = 0.
  - req & miss: latch req_addr, victim_addr, op (write if req_we, else read). Next state WB if dirty, else FETCH.
  - stall = req & miss, combinational in this cycle.
  - req_re & req_we together is treated as a write.
  - hit & miss together is treated as miss.
- WB:
  - mem_req = 1, mem_wr = 1, mem_addr = latched victim_addr.
  - Counter runs 0..MEM_LATENCY-1; at MEM_LATENCY-1 -> FETCH, counter cleared.
  - Occupies exactly MEM_LATENCY cycles.
- FETCH:
  - mem_req = 1, mem_wr = 0, mem_addr = latched req_addr.
  - Exactly MEM_LATENCY cycles, then -> FILL.
- FILL: one cycle.
  - fill_wr_we = 1 if latched op is write; fill_rd_we = 1 if read; never both.
  - -> DONE.
- DONE: one cycle.
  - done = 1, stall = 0; miss input ignored (cache still settling); -> IDLE.
- stall = 1 in WB, FETCH and FILL.
- Outside WB/FETCH: mem_req = 0, mem_wr = 0, mem_addr = 0.
- Latency, counted from the IDLE cycle seeing the miss as cycle 0:
  - clean miss: FILL at cycle MEM_LATENCY+1, done at MEM_LATENCY+2;
  - dirty miss: add MEM_LATENCY.
- Requester inputs are don't-care while stall = 1; the controller uses only latched values.
- Counter never wraps; it is cleared on every state change.

Optional Feature:
- Macro: CACHE_MISS_CTRL_PERF_EN.
- Defined: adds 32-bit outputs hit_count, miss_count, wb_count.
  - hit_count increments on an IDLE req & hit cycle (not in DONE).
  - miss_count increments on miss acceptance.
  - wb_count increments on the IDLE->WB transition.
  - All saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package cache_ctrl_pkg:
  - state enum (IDLE, WB, FETCH, FILL, DONE);
  - op enum (OP_RD, OP_WR);
  - default MEM_LATENCY constant.
- One sub-module, mem_latency_counter:
  - inputs: clear, enable, terminal value;
  - output: `expired` when count == MEM_LATENCY-1.

Test Plan:
- Reset, then write hit (req_we=1, addr 32'h50, hit=1): stall=0; no mem_req, no fill strobe, done=0.
- Clean read miss (addr 32'h2006, miss=1, dirty=0), MEM_LATENCY=20:
  - stall from cycle 0;
  - mem_req=1, mem_wr=0, mem_addr=32'h2006 for cycles 1..20;
  - fill_rd_we at cycle 21; done at 22.
- Dirty write miss (addr 32'h1006, victim 32'h0006, dirty=1):
  - mem_wr=1, mem_addr=32'h0006 for 20 cycles;
  - then fetch of 32'h1006 for 20 cycles;
  - fill_wr_we at cycle 41; done at 42.
- req_re=req_we=1 on miss: fill_wr_we pulses, fill_rd_we stays 0.
- reset_n=0 at cycle 10 of FETCH: next edge all outputs 0, state IDLE; no fill pulse afterwards.
- With CACHE_MISS_CTRL_PERF_EN defined, 3 hits + 2 misses (1 dirty): hit_count=3, miss_count=2, wb_count=1.
